// File: rtl/cgp_frame_pkg.sv
// Shared constants, state encoding and the quantizer function for the CGP feature framer.
package cgp_frame_pkg;

  localparam int N_FEAT  = 9;
  localparam int RAW_W   = 8;
  localparam int Q_W     = 2;
  localparam int FRAME_W = N_FEAT * Q_W;

  typedef enum logic [1:0] {FILL, FULL, DROP} frame_state_t;

  // Unsigned thresholding; a sample equal to a threshold takes the higher code.
  function automatic logic [Q_W-1:0] quantize(
    input logic [RAW_W-1:0] x,
    input logic [RAW_W-1:0] t1,
    input logic [RAW_W-1:0] t2,
    input logic [RAW_W-1:0] t3
  );
    if (x >= t3)      return 2'd3;
    else if (x >= t2) return 2'd2;
    else if (x >= t1) return 2'd1;
    else              return 2'd0;
  endfunction

endpackage

// File: rtl/cgp_quantizer.sv
// Combinational 8-bit to 2-bit feature quantizer with fixed thresholds.
module cgp_quantizer
  import cgp_frame_pkg::*;
#(
  parameter logic [RAW_W-1:0] T1 = RAW_W'(64),
  parameter logic [RAW_W-1:0] T2 = RAW_W'(128),
  parameter logic [RAW_W-1:0] T3 = RAW_W'(192)
) (
  input  logic [RAW_W-1:0] x,
  output logic [Q_W-1:0]   q
);

  assign q = quantize(x, T1, T2, T3);

endmodule

// File: rtl/cgp_feature_framer.sv
// Quantizes a raw sample stream into 9-feature frames and hands them to the classifier,
// double-buffered so the next frame can fill while the current one is held.
module cgp_feature_framer #(
  parameter int               N_FEAT = 9,
  parameter int               RAW_W  = 8,
  parameter int               Q_W    = 2,
  parameter logic [RAW_W-1:0] T1     = RAW_W'(64),
  parameter logic [RAW_W-1:0] T2     = RAW_W'(128),
  parameter logic [RAW_W-1:0] T3     = RAW_W'(192)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [RAW_W-1:0]        s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [N_FEAT*Q_W-1:0]   m_frame,
  output logic                    err,
  output logic [15:0]             frame_cnt
);
  import cgp_frame_pkg::*;

  localparam int         FRAME_W  = N_FEAT * Q_W;
  localparam logic [3:0] LAST_IDX = 4'(N_FEAT - 1);

  if (!((T1 < T2) && (T2 < T3))) begin : g_bad_thresholds
    $error("cgp_feature_framer: thresholds must satisfy T1 < T2 < T3");
  end

  frame_state_t       state, state_n;
  logic [3:0]         idx, idx_n;
  logic [FRAME_W-1:0] asm_frame, asm_n, full_frame, load_frame;
  logic [Q_W-1:0]     q;
  logic               beat, slot_free, load, err_n;

  cgp_quantizer #(
    .T1 (T1),
    .T2 (T2),
    .T3 (T3)
  ) u_quantizer (
    .x (s_data),
    .q (q)
  );

  assign beat      = s_valid && s_ready;
  assign slot_free = !m_valid || m_ready;

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    asm_n      = asm_frame;
    load       = 1'b0;
    load_frame = asm_frame;
    err_n      = 1'b0;
    full_frame = asm_frame;
    full_frame[FRAME_W-1 -: Q_W] = q;
    unique case (state)
      FILL: begin
        if (beat) begin
          if (idx < LAST_IDX) begin
            if (s_last) begin
              idx_n = 4'd0;
              err_n = 1'b1;
            end else begin
              asm_n[int'(idx)*Q_W +: Q_W] = q;
              idx_n = idx + 4'd1;
            end
          end else if (s_last) begin
            // The final sample goes straight into the outgoing frame when the slot is free.
            asm_n = full_frame;
            if (slot_free) begin
              load       = 1'b1;
              load_frame = full_frame;
              idx_n      = 4'd0;
            end else begin
              state_n = FULL;
            end
          end else begin
            err_n   = 1'b1;
            idx_n   = 4'd0;
            state_n = DROP;
          end
        end
      end
      FULL: begin
        if (slot_free) begin
          load       = 1'b1;
          load_frame = asm_frame;
          idx_n      = 4'd0;
          state_n    = FILL;
        end
      end
      DROP: begin
        if (beat && s_last) begin
          idx_n   = 4'd0;
          state_n = FILL;
        end
      end
      default: begin
        idx_n   = 4'd0;
        state_n = FILL;
      end
    endcase
  end

  // s_ready is registered from the next state so it never depends combinationally on inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      idx       <= 4'd0;
      asm_frame <= '0;
      s_ready   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      asm_frame <= asm_n;
      s_ready   <= (state_n != FULL);
      err       <= err_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid   <= 1'b0;
      m_frame   <= '0;
      frame_cnt <= 16'd0;
    end else begin
      if (load) begin
        m_valid <= 1'b1;
        m_frame <= load_frame;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      if (m_valid && m_ready) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cgp_feature_framer.sv
// Directed self-checking bench for cgp_feature_framer; expected frames are hand-computed.
module tb_cgp_feature_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [17:0] m_frame;
  logic        err;
  logic [15:0] frame_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt;

  // Sample 0 sits in the low byte.
  localparam logic [71:0] BOUND_DATA = {8'd200, 8'd255, 8'd192, 8'd191, 8'd128,
                                        8'd127, 8'd64, 8'd63, 8'd0};
  localparam logic [17:0] BOUND_Q    = 18'h3FA50;
  localparam logic [71:0] A_DATA     = {8'd191, 8'd192, 8'd63, 8'd64, 8'd250,
                                        8'd150, 8'd100, 8'd10, 8'd200};
  localparam logic [17:0] A_Q        = 18'h2C793;
  localparam logic [71:0] B_DATA     = {8'd33, 8'd193, 8'd65, 8'd129, 8'd1,
                                        8'd127, 8'd128, 8'd255, 8'd0};
  localparam logic [17:0] B_Q        = 18'h0D86C;

  cgp_feature_framer dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_frame   (m_frame),
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic send_frame(input logic [71:0] data, input int n, input int last_at,
                            input logic ready_on_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = data[(i % 9)*8 +: 8];
      s_last  = (i == last_at);
      if (ready_on_last && (i == last_at)) m_ready = 1'b1;
    end
  endtask

  task automatic end_stream();
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = 8'd0; s_last = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_ready: got %b expected 0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_frame !== 18'h0) begin errors++; $display("[TB] FAIL reset_m_frame: got %h expected 0", m_frame); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_s_ready: got %b expected 1", s_ready); end
    exp_cnt = 16'd0;
  endtask

  task automatic test_quant_boundary();
    m_ready = 1'b1;
    send_frame(BOUND_DATA, 9, 8, 1'b0);
    end_stream();
    checks++; if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL bound_m_valid: got %b expected 1", m_valid); end
    checks++; if (m_frame !== BOUND_Q) begin errors++; $display("[TB] FAIL bound_m_frame: got %h expected %h", m_frame, BOUND_Q); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL bound_err: got %b expected 0", err); end
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL bound_drained: got %b expected 0", m_valid); end
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("[TB] FAIL bound_frame_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_back_pressure();
    m_ready = 1'b0;
    send_frame(A_DATA, 9, 8, 1'b0);
    send_frame(B_DATA, 9, 8, 1'b0);
    end_stream();
    checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_s_ready: got %b expected 0", s_ready); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_held_valid: got %b expected 1", m_valid); end
    checks++; if (m_frame !== A_Q) begin errors++; $display("[TB] FAIL bp_held_frame: got %h expected %h", m_frame, A_Q); end
    repeat (3) @(negedge clk);
    checks++; if (m_frame !== A_Q || s_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_still_held: got frame %h ready %b expected %h ready 0", m_frame, s_ready, A_Q); end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_swap_valid: got %b expected 1", m_valid); end
    checks++; if (m_frame !== B_Q) begin errors++; $display("[TB] FAIL bp_swap_frame: got %h expected %h", m_frame, B_Q); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_swap_s_ready: got %b expected 1", s_ready); end
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("[TB] FAIL bp_swap_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
    m_ready = 1'b1;
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (m_valid !== 1'b0 || frame_cnt !== exp_cnt) begin errors++; $display("[TB] FAIL bp_drain: got valid %b cnt %0d expected valid 0 cnt %0d", m_valid, frame_cnt, exp_cnt); end
  endtask

  task automatic test_short_frame();
    m_ready = 1'b1;
    send_frame(A_DATA, 5, 4, 1'b0);
    end_stream();
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL short_err: got %b expected 1", err); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL short_no_frame: got %b expected 0", m_valid); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL short_err_pulse: got %b expected 0", err); end
    send_frame(A_DATA, 9, 8, 1'b0);
    end_stream();
    checks++; if (m_valid !== 1'b1 || m_frame !== A_Q) begin errors++; $display("[TB] FAIL short_recover: got valid %b frame %h expected 1 %h", m_valid, m_frame, A_Q); end
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("[TB] FAIL short_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_long_frame();
    logic saw_valid;
    saw_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_valid) saw_valid = 1'b1;
      if (i == 9) begin
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL long_err: got %b expected 1", err); end
      end
      if (i == 10) begin
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL long_err_pulse: got %b expected 0", err); end
      end
      s_valid = 1'b1;
      s_data  = A_DATA[(i % 9)*8 +: 8];
      s_last  = (i == 11);
    end
    end_stream();
    if (m_valid) saw_valid = 1'b1;
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("[TB] FAIL long_no_frame: got %b expected 0", saw_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL long_drop_err: got %b expected 0", err); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL long_s_ready: got %b expected 1", s_ready); end
    send_frame(B_DATA, 9, 8, 1'b0);
    end_stream();
    checks++; if (m_valid !== 1'b1 || m_frame !== B_Q) begin errors++; $display("[TB] FAIL long_recover: got valid %b frame %h expected 1 %h", m_valid, m_frame, B_Q); end
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("[TB] FAIL long_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    send_frame(A_DATA, 9, 8, 1'b0);
    send_frame(B_DATA, 4, -1, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_m_valid: got %b expected 0", m_valid); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rstmid_cnt: got %0d expected 0", frame_cnt); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_s_ready: got %b expected 0", s_ready); end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 16'd0;
    @(negedge clk);
    m_ready = 1'b1;
    send_frame(B_DATA, 9, 8, 1'b0);
    end_stream();
    checks++; if (m_valid !== 1'b1 || m_frame !== B_Q) begin errors++; $display("[TB] FAIL rstmid_fresh: got valid %b frame %h expected 1 %h", m_valid, m_frame, B_Q); end
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("[TB] FAIL rstmid_fresh_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    int stalls;
    stalls = 0;
    m_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 9; i++) begin
        @(negedge clk);
        if (!s_ready) stalls++;
        s_valid = 1'b1;
        s_data  = (f % 2 == 0) ? A_DATA[i*8 +: 8] : B_DATA[i*8 +: 8];
        s_last  = (i == 8);
      end
    end
    end_stream();
    checks++; if (stalls != 0) begin errors++; $display("[TB] FAIL b2b_stalls: got %0d expected 0", stalls); end
    checks++; if (m_frame !== B_Q) begin errors++; $display("[TB] FAIL b2b_last_frame: got %h expected %h", m_frame, B_Q); end
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd6;
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("[TB] FAIL b2b_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
    // Held frame drained on the same edge a new frame completes.
    m_ready = 1'b0;
    send_frame(A_DATA, 9, 8, 1'b0);
    send_frame(B_DATA, 9, 8, 1'b1);
    end_stream();
    m_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (m_valid !== 1'b1 || m_frame !== B_Q) begin errors++; $display("[TB] FAIL swap_fill: got valid %b frame %h expected 1 %h", m_valid, m_frame, B_Q); end
    checks++; if (frame_cnt !== exp_cnt || s_ready !== 1'b1) begin errors++; $display("[TB] FAIL swap_fill_cnt: got cnt %0d ready %b expected %0d 1", frame_cnt, s_ready, exp_cnt); end
    m_ready = 1'b1;
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (m_valid !== 1'b0 || frame_cnt !== exp_cnt) begin errors++; $display("[TB] FAIL swap_drain: got valid %b cnt %0d expected 0 %0d", m_valid, frame_cnt, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_quant_boundary();
    test_back_pressure();
    test_short_frame();
    test_long_frame();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
